nasti_lite_mem_writer: RTL and testbench

NASTI-lite write endpoint that sits directly downstream of `nasti_lite_writer`. It accepts single-beat lite AW/W transactions and turns each one into a one-cycle write strobe on a word-addressed synchronous memory or register-file port. It decodes the address against a configured window and returns one B response per transaction through a small response FIFO. This keeps B back-pressure from stalling the memory side until the FIFO fills.

---
 rtl/nasti_lite_pkg.sv | 9 +
 rtl/nasti_lite_resp_fifo.sv | 54 +++++
 rtl/nasti_lite_mem_writer.sv | 155 +++++++++++++++
 tb/tb_nasti_lite_mem_writer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nasti_lite_pkg.sv
// Shared NASTI-lite definitions: response codes used by lite endpoints.
package nasti_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/nasti_lite_resp_fifo.sv
// Generic circular response FIFO; head is visible whenever empty is low.
module nasti_lite_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nasti_lite_mem_writer.sv
// NASTI-lite write endpoint: pairs AW/W, strobes a word-addressed memory port,
// and queues one B response per write.
module nasti_lite_mem_writer
    import nasti_lite_pkg::*;
#(
    parameter int                    ID_WIDTH   = 1,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    USER_WIDTH = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MEM_WORDS  = 64,
    parameter int                    B_DEPTH    = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [ID_WIDTH-1:0]          lite_aw_id,
    input  logic [ADDR_WIDTH-1:0]        lite_aw_addr,
    input  logic [2:0]                   lite_aw_prot,
    input  logic [3:0]                   lite_aw_qos,
    input  logic [3:0]                   lite_aw_region,
    input  logic [USER_WIDTH-1:0]        lite_aw_user,
    input  logic                         lite_aw_valid,
    output logic                         lite_aw_ready,
    input  logic [DATA_WIDTH-1:0]        lite_w_data,
    input  logic [DATA_WIDTH/8-1:0]      lite_w_strb,
    input  logic [USER_WIDTH-1:0]        lite_w_user,
    input  logic                         lite_w_valid,
    output logic                         lite_w_ready,
    output logic [ID_WIDTH-1:0]          lite_b_id,
    output logic [1:0]                   lite_b_resp,
    output logic [USER_WIDTH-1:0]        lite_b_user,
    output logic                         lite_b_valid,
    input  logic                         lite_b_ready,
    output logic                         mem_we,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [DATA_WIDTH/8-1:0]      mem_wstrb
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LB     = $clog2(STRB_W);
    localparam int MA_W   = $clog2(MEM_WORDS);
    localparam int CMP_W  = ADDR_WIDTH + 32;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $fatal(1, "nasti_lite_mem_writer: DATA_WIDTH must be 32 or 64");
    end
    if (USER_WIDTH < 1 || ID_WIDTH < 1) begin : g_bad_uw
        $fatal(1, "nasti_lite_mem_writer: USER_WIDTH and ID_WIDTH must be > 0");
    end
    if ((int'(BASE_ADDR) % STRB_W) != 0) begin : g_bad_base
        $fatal(1, "nasti_lite_mem_writer: BASE_ADDR must be word aligned");
    end
    if (MEM_WORDS < 2 || B_DEPTH < 1) begin : g_bad_size
        $fatal(1, "nasti_lite_mem_writer: MEM_WORDS >= 2 and B_DEPTH >= 1 required");
    end

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [1:0]            resp;
        logic [USER_WIDTH-1:0] user;
    } b_entry_t;

    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [USER_WIDTH-1:0] aw_user;
    logic                  aw_held;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  w_held;

    logic                  aw_hs, w_hs, commit, b_full, b_empty;
    logic [ADDR_WIDTH:0]   off;
    logic [ADDR_WIDTH-1:0] word;
    logic                  in_range, aligned;
    logic [1:0]            resp;
    b_entry_t              b_push, b_head;

    assign commit        = aw_held && w_held && !b_full;
    assign lite_aw_ready = !aw_held || commit;
    assign lite_w_ready  = !w_held || commit;
    assign aw_hs         = lite_aw_valid && lite_aw_ready;
    assign w_hs          = lite_w_valid && lite_w_ready;

    // Address reset to the window base so the idle memory port shows word 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held <= 1'b0;
            aw_id   <= '0;
            aw_addr <= BASE_ADDR;
            aw_user <= '0;
            w_held  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_id   <= lite_aw_id;
                aw_addr <= lite_aw_addr;
                aw_user <= lite_aw_user;
            end else if (commit) begin
                aw_held <= 1'b0;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= lite_w_data;
                w_strb <= lite_w_strb;
            end else if (commit) begin
                w_held <= 1'b0;
            end
        end
    end

    // Extra top bit of off flags addresses below the window base.
    assign off      = {1'b0, aw_addr} - {1'b0, BASE_ADDR};
    assign word     = off[ADDR_WIDTH-1:0] >> LB;
    assign in_range = !off[ADDR_WIDTH] && ({32'd0, word} < CMP_W'(MEM_WORDS));
    assign aligned  = (aw_addr[LB-1:0] == '0);

    always_comb begin
        resp = RESP_OKAY;
        if (!in_range)     resp = RESP_DECERR;
        else if (!aligned) resp = RESP_SLVERR;
    end

    assign mem_addr  = MA_W'(word);
    assign mem_wdata = w_data;
    assign mem_wstrb = w_strb;
    assign mem_we    = commit && (resp == RESP_OKAY) && (|w_strb);

    assign b_push = '{id: aw_id, resp: resp, user: aw_user};

    nasti_lite_resp_fifo #(
        .WIDTH ($bits(b_entry_t)),
        .DEPTH (B_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (commit),
        .push_data (b_push),
        .pop       (lite_b_valid && lite_b_ready),
        .full      (b_full),
        .empty     (b_empty),
        .head      (b_head)
    );

    assign lite_b_valid = !b_empty;
    assign lite_b_id    = b_head.id;
    assign lite_b_resp  = b_head.resp;
    assign lite_b_user  = b_head.user;

    logic unused;
    assign unused = ^{lite_aw_prot, lite_aw_qos, lite_aw_region, lite_w_user};

endmodule

// File: tb/tb_nasti_lite_mem_writer.sv
// Directed and randomized bench for nasti_lite_mem_writer against a queue-based reference.
module tb_nasti_lite_mem_writer;

    localparam int         IDW  = 4;
    localparam int         AW   = 8;
    localparam int         DW   = 32;
    localparam int         UW   = 2;
    localparam int         MW   = 16;
    localparam int         BD   = 2;
    localparam logic [7:0] BASE = 8'h40;

    logic           clk, rstn;
    logic [IDW-1:0] lite_aw_id;
    logic [AW-1:0]  lite_aw_addr;
    logic [2:0]     lite_aw_prot;
    logic [3:0]     lite_aw_qos, lite_aw_region;
    logic [UW-1:0]  lite_aw_user;
    logic           lite_aw_valid, lite_aw_ready;
    logic [DW-1:0]  lite_w_data;
    logic [3:0]     lite_w_strb;
    logic [UW-1:0]  lite_w_user;
    logic           lite_w_valid, lite_w_ready;
    logic [IDW-1:0] lite_b_id;
    logic [1:0]     lite_b_resp;
    logic [UW-1:0]  lite_b_user;
    logic           lite_b_valid, lite_b_ready;
    logic           mem_we;
    logic [3:0]     mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [3:0]     mem_wstrb;

    nasti_lite_mem_writer #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW),
        .BASE_ADDR(BASE), .MEM_WORDS(MW), .B_DEPTH(BD)
    ) dut (
        .clk(clk), .rstn(rstn),
        .lite_aw_id(lite_aw_id), .lite_aw_addr(lite_aw_addr), .lite_aw_prot(lite_aw_prot),
        .lite_aw_qos(lite_aw_qos), .lite_aw_region(lite_aw_region), .lite_aw_user(lite_aw_user),
        .lite_aw_valid(lite_aw_valid), .lite_aw_ready(lite_aw_ready),
        .lite_w_data(lite_w_data), .lite_w_strb(lite_w_strb), .lite_w_user(lite_w_user),
        .lite_w_valid(lite_w_valid), .lite_w_ready(lite_w_ready),
        .lite_b_id(lite_b_id), .lite_b_resp(lite_b_resp), .lite_b_user(lite_b_user),
        .lite_b_valid(lite_b_valid), .lite_b_ready(lite_b_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {logic [IDW-1:0] id; logic [1:0] resp; logic [UW-1:0] user;} bexp_t;
    typedef struct {logic [3:0] addr; logic [DW-1:0] data; logic [3:0] strb;} wexp_t;

    bexp_t exp_b[$];
    wexp_t exp_w[$];
    int    we_cyc[$];
    int    pop_cyc[$];
    bexp_t mb;
    wexp_t mw;

    logic [IDW-1:0] t_id[32];
    logic [AW-1:0]  t_addr[32];
    logic [DW-1:0]  t_data[32];
    logic [3:0]     t_strb[32];
    logic [UW-1:0]  t_user[32];
    int             s_n, aw_i, w_i;
    bit             rand_bready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the window rules, in plain integers.
    function automatic logic [1:0] ref_resp(input int addr);
        int off;
        off = addr - int'(BASE);
        if (off < 0 || off / 4 >= MW) return 2'b11;
        if (addr % 4 != 0) return 2'b10;
        return 2'b00;
    endfunction

    task automatic expect_txn(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic [3:0] strb,
                              input logic [UW-1:0] user);
        logic [1:0] r;
        r = ref_resp(int'(addr));
        exp_b.push_back('{id, r, user});
        if (r == 2'b00 && strb != 4'h0)
            exp_w.push_back('{4'((int'(addr) - int'(BASE)) / 4), data, strb});
    endtask

    // Monitor: every memory write and every B pop must match the next expectation.
    always @(negedge clk) begin
        cyc++;
        if (rstn) begin
            if (mem_we) begin
                we_cyc.push_back(cyc);
                chk("mon_we_expected", 64'(exp_w.size() != 0), 64'd1);
                if (exp_w.size() != 0) begin
                    mw = exp_w.pop_front();
                    chk("mon_mem_addr", 64'(mem_addr), 64'(mw.addr));
                    chk("mon_mem_wdata", 64'(mem_wdata), 64'(mw.data));
                    chk("mon_mem_wstrb", 64'(mem_wstrb), 64'(mw.strb));
                end
            end
            if (lite_b_valid && lite_b_ready) begin
                pop_cyc.push_back(cyc);
                chk("mon_b_expected", 64'(exp_b.size() != 0), 64'd1);
                if (exp_b.size() != 0) begin
                    mb = exp_b.pop_front();
                    chk("mon_b_id", 64'(lite_b_id), 64'(mb.id));
                    chk("mon_b_resp", 64'(lite_b_resp), 64'(mb.resp));
                    chk("mon_b_user", 64'(lite_b_user), 64'(mb.user));
                end
            end
        end
    end

    task automatic directed_pair(input string tag, input logic [IDW-1:0] id,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic [3:0] strb, input logic [UW-1:0] user);
        logic [1:0] r;
        logic       we_exp;
        r = ref_resp(int'(addr));
        we_exp = (r == 2'b00) && (strb != 4'h0);
        lite_b_ready = 1'b0;
        lite_aw_id = id; lite_aw_addr = addr; lite_aw_user = user; lite_aw_valid = 1'b1;
        lite_w_data = data; lite_w_strb = strb; lite_w_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_aw_ready"}, 64'(lite_aw_ready), 64'd1);
        chk({tag, "_w_ready"}, 64'(lite_w_ready), 64'd1);
        @(posedge clk);
        expect_txn(id, addr, data, strb, user);
        #1 lite_aw_valid = 1'b0; lite_w_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_we_t1"}, 64'(mem_we), 64'(we_exp));
        if (we_exp) chk({tag, "_addr_t1"}, 64'(mem_addr), 64'((int'(addr) - int'(BASE)) / 4));
        chk({tag, "_bvalid_t1"}, 64'(lite_b_valid), 64'd0);
        @(posedge clk);
        #1 lite_b_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_we_t2"}, 64'(mem_we), 64'd0);
        chk({tag, "_bvalid_t2"}, 64'(lite_b_valid), 64'd1);
        chk({tag, "_bid"}, 64'(lite_b_id), 64'(id));
        chk({tag, "_bresp"}, 64'(lite_b_resp), 64'(r));
        chk({tag, "_buser"}, 64'(lite_b_user), 64'(user));
        @(posedge clk);
        #1 lite_b_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_bvalid_t3"}, 64'(lite_b_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic stream_start(input int n);
        s_n = n; aw_i = 0; w_i = 0;
    endtask

    // One cycle of a source that offers txn aw_i / w_i until each is accepted.
    task automatic stream_step();
        logic ar, wr;
        if (rand_bready) lite_b_ready = 1'($urandom_range(0, 1));
        lite_aw_valid = (aw_i < s_n);
        if (aw_i < s_n) begin
            lite_aw_id = t_id[aw_i]; lite_aw_addr = t_addr[aw_i]; lite_aw_user = t_user[aw_i];
        end
        lite_w_valid = (w_i < s_n);
        if (w_i < s_n) begin
            lite_w_data = t_data[w_i]; lite_w_strb = t_strb[w_i];
        end
        @(negedge clk);
        ar = lite_aw_ready;
        wr = lite_w_ready;
        @(posedge clk);
        if (lite_aw_valid && ar) begin
            expect_txn(t_id[aw_i], t_addr[aw_i], t_data[aw_i], t_strb[aw_i], t_user[aw_i]);
            aw_i++;
        end
        if (lite_w_valid && wr) w_i++;
        #1 lite_aw_valid = 1'b0; lite_w_valid = 1'b0;
    endtask

    task automatic stream_drain(input int budget, input string tag);
        int k;
        k = 0;
        while ((aw_i < s_n || w_i < s_n || exp_b.size() != 0) && k < budget) begin
            stream_step();
            k++;
        end
        chk({tag, "_completed"}, 64'(k < budget), 64'd1);
        chk({tag, "_wq_empty"}, 64'(exp_w.size()), 64'd0);
    endtask

    task automatic fill_seq(input int n);
        for (int i = 0; i < n; i++) begin
            t_id[i] = IDW'(i); t_addr[i] = BASE + 8'(4 * (i % MW));
            t_data[i] = $urandom; t_strb[i] = 4'hF; t_user[i] = UW'(i);
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            t_id[i] = IDW'($urandom);
            if ($urandom_range(0, 9) < 6) t_addr[i] = BASE + 8'(4 * $urandom_range(0, MW - 1));
            else                          t_addr[i] = 8'($urandom_range(0, 255));
            t_data[i] = $urandom; t_strb[i] = 4'($urandom_range(0, 15)); t_user[i] = UW'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; rand_bready = 1'b0; s_n = 0; aw_i = 0; w_i = 0;
        lite_aw_id = '0; lite_aw_addr = '0; lite_aw_prot = '0; lite_aw_qos = '0;
        lite_aw_region = '0; lite_aw_user = '0; lite_aw_valid = 1'b0;
        lite_w_data = '0; lite_w_strb = '0; lite_w_user = '0; lite_w_valid = 1'b0;
        lite_b_ready = 1'b0;

        // Reset values
        #12;
        chk("rst_aw_ready", 64'(lite_aw_ready), 64'd1);
        chk("rst_w_ready", 64'(lite_w_ready), 64'd1);
        chk("rst_b_valid", 64'(lite_b_valid), 64'd0);
        chk("rst_b_id", 64'(lite_b_id), 64'd0);
        chk("rst_b_resp", 64'(lite_b_resp), 64'd0);
        chk("rst_b_user", 64'(lite_b_user), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Same-cycle AW/W, word 4 of the window
        directed_pair("basic", 4'd3, BASE + 8'h10, 32'hDEADBEEF, 4'hF, 2'd1);

        // W first, AW three cycles later
        we_cyc.delete();
        lite_b_ready = 1'b0;
        lite_w_data = 32'hA5A5_0F0F; lite_w_strb = 4'b0011; lite_w_valid = 1'b1;
        @(posedge clk);
        #1 lite_w_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("wfirst_w_ready_low", 64'(lite_w_ready), 64'd0);
            chk("wfirst_no_we", 64'(mem_we), 64'd0);
            @(posedge clk);
            #1;
        end
        lite_aw_id = 4'd5; lite_aw_addr = BASE + 8'h3C; lite_aw_user = 2'd2; lite_aw_valid = 1'b1;
        @(negedge clk);
        chk("wfirst_w_ready_wait", 64'(lite_w_ready), 64'd0);
        chk("wfirst_aw_ready", 64'(lite_aw_ready), 64'd1);
        @(posedge clk);
        expect_txn(4'd5, BASE + 8'h3C, 32'hA5A5_0F0F, 4'b0011, 2'd2);
        #1 lite_aw_valid = 1'b0;
        @(negedge clk);
        chk("wfirst_we", 64'(mem_we), 64'd1);
        chk("wfirst_w_ready_commit", 64'(lite_w_ready), 64'd1);
        @(posedge clk);
        #1 lite_b_ready = 1'b1;
        @(negedge clk);
        chk("wfirst_bvalid", 64'(lite_b_valid), 64'd1);
        chk("wfirst_bresp", 64'(lite_b_resp), 64'd0);
        chk("wfirst_bid", 64'(lite_b_id), 64'd5);
        @(posedge clk);
        #1 lite_b_ready = 1'b0;
        chk("wfirst_one_we", 64'(we_cyc.size()), 64'd1);

        // Window boundaries, misalignment, empty strobe
        directed_pair("above_window", 4'd6, BASE + 8'(MW * 4), 32'h1111_2222, 4'hF, 2'd0);
        directed_pair("below_window", 4'd7, BASE - 8'd4, 32'h3333_4444, 4'hF, 2'd3);
        directed_pair("unaligned", 4'd8, BASE + 8'h02, 32'h5555_6666, 4'hF, 2'd1);
        directed_pair("zero_strb", 4'd9, BASE + 8'h08, 32'h7777_8888, 4'h0, 2'd2);
        directed_pair("last_word", 4'd10, BASE + 8'(MW * 4 - 4), 32'h9999_AAAA, 4'b1000, 2'd0);

        // B stall with a two-entry FIFO
        we_cyc.delete(); pop_cyc.delete();
        lite_b_ready = 1'b0;
        fill_seq(5);
        stream_start(5);
        repeat (6) stream_step();
        @(negedge clk);
        chk("stall_two_commits", 64'(we_cyc.size()), 64'd2);
        chk("stall_aw_ready_low", 64'(lite_aw_ready), 64'd0);
        chk("stall_w_ready_low", 64'(lite_w_ready), 64'd0);
        chk("stall_b_valid", 64'(lite_b_valid), 64'd1);
        @(posedge clk);
        #1 lite_b_ready = 1'b1;
        stream_drain(40, "stall");
        chk("stall_total_we", 64'(we_cyc.size()), 64'd5);
        chk("stall_total_pops", 64'(pop_cyc.size()), 64'd5);
        if (we_cyc.size() > 2 && pop_cyc.size() > 0)
            chk("stall_third_commit_gap", 64'(we_cyc[2] - pop_cyc[0]), 64'd1);

        // Randomized traffic with random B back-pressure
        rand_bready = 1'b1;
        fill_random(24);
        stream_start(24);
        stream_drain(600, "random");
        rand_bready = 1'b0;

        // Back-to-back stream, B always ready
        lite_b_ready = 1'b1;
        we_cyc.delete();
        fill_seq(8);
        stream_start(8);
        stream_drain(40, "b2b");
        chk("b2b_we_count", 64'(we_cyc.size()), 64'd8);
        for (int i = 1; i < 8; i++)
            if (i < we_cyc.size()) chk("b2b_consecutive", 64'(we_cyc[i] - we_cyc[i-1]), 64'd1);

        // Asynchronous reset in the middle of a stream
        fill_seq(8);
        stream_start(8);
        repeat (4) stream_step();
        @(negedge clk);
        chk("mid_b_valid", 64'(lite_b_valid), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async_b_valid", 64'(lite_b_valid), 64'd0);
        chk("async_mem_we", 64'(mem_we), 64'd0);
        chk("async_aw_ready", 64'(lite_aw_ready), 64'd1);
        chk("async_w_ready", 64'(lite_w_ready), 64'd1);
        exp_b.delete(); exp_w.delete();
        s_n = 0;
        @(posedge clk);
        #1 rstn = 1'b1;
        directed_pair("after_reset", 4'd12, BASE + 8'h20, 32'hCAFE_F00D, 4'b0110, 2'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
